// File: rtl/ay_bus_master.sv
// Host-side initiator for the AY-compatible sound-card bus.
// Turns single-word requests into phased BDIR/BC2/BC1 cycles with post-access recovery.
module ay_bus_master #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned ADDR_WAIT  = 136,
    parameter int unsigned DATA_WAIT  = 664,
    parameter int unsigned GAP_CYC    = 2
) (
    input  logic       fclk,
    input  logic       res_n,
    input  logic       req,
    input  logic [1:0] cmd,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic [7:0] rdata,
    output logic       rvalid,
    output logic [7:0] ayd_o,
    output logic       ayd_oe,
    input  logic [7:0] ayd_i,
    output logic       aybdir,
    output logic       aybc2,
    output logic       aybc1,
    output logic       aya8,
    output logic       aya9_n
);

    localparam int unsigned PH_W   = 4;
    localparam int unsigned RC_W   = 10;
    localparam int unsigned PH_MAX = (1 << PH_W) - 1;
    localparam int unsigned RC_MAX = (1 << RC_W) - 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_RECOV  = 3'd4;

    localparam logic [1:0] CMD_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR   = 2'b01;
    localparam logic [1:0] CMD_RD   = 2'b10;
    localparam logic [1:0] CMD_CFG  = 2'b11;

    // (BDIR,BC2,BC1) codes
    localparam logic [2:0] BUS_INACT = 3'b010;
    localparam logic [2:0] BUS_ADDR  = 3'b111;
    localparam logic [2:0] BUS_WR    = 3'b110;
    localparam logic [2:0] BUS_RD    = 3'b011;

    logic [2:0]      state_q, state_d;
    logic [PH_W-1:0] ph_cnt_q, ph_cnt_d;
    logic [RC_W-1:0] rc_cnt_q, rc_cnt_d;
    logic [1:0]      cmd_q, cmd_d;

    logic            ready_d;
    logic [7:0]      rdata_d;
    logic            rvalid_d;
    logic [7:0]      ayd_o_d;
    logic            ayd_oe_d;
    logic [2:0]      bus_d;
    logic            aya8_d;
    logic            aya9_n_d;

    function automatic logic [2:0] strobe_code(input logic [1:0] c);
        case (c)
            CMD_ADDR: strobe_code = BUS_ADDR;
            CMD_WR:   strobe_code = BUS_WR;
            CMD_RD:   strobe_code = BUS_RD;
            default:  strobe_code = BUS_ADDR;
        endcase
    endfunction

    function automatic logic [RC_W-1:0] recov_load(input logic [1:0] c);
        case (c)
            CMD_ADDR: recov_load = RC_W'(ADDR_WAIT);
            CMD_WR:   recov_load = RC_W'(DATA_WAIT);
            default:  recov_load = RC_W'(GAP_CYC);
        endcase
    endfunction

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_d  = state_q;
        ph_cnt_d = ph_cnt_q;
        rc_cnt_d = rc_cnt_q;
        cmd_d    = cmd_q;
        ready_d  = ready;
        rdata_d  = rdata;
        rvalid_d = 1'b0;
        ayd_o_d  = ayd_o;
        ayd_oe_d = ayd_oe;
        bus_d    = {aybdir, aybc2, aybc1};
        aya8_d   = aya8;
        aya9_n_d = aya9_n;

        case (state_q)
            S_IDLE: begin
                if (req && ready) begin
                    state_d  = S_SETUP;
                    ph_cnt_d = PH_W'(SETUP_CYC);
                    cmd_d    = cmd;
                    ready_d  = 1'b0;
                    ayd_o_d  = (cmd == CMD_CFG) ? {4'hF, wdata[3:0]} : wdata;
                    ayd_oe_d = (cmd != CMD_RD);
                    bus_d    = BUS_INACT;
                    aya8_d   = 1'b1;
                    aya9_n_d = 1'b0;
                end
            end

            S_SETUP: begin
                if (ph_cnt_q == PH_W'(1)) begin
                    state_d  = S_STROBE;
                    ph_cnt_d = PH_W'(STROBE_CYC);
                    bus_d    = strobe_code(cmd_q);
                end else begin
                    ph_cnt_d = ph_cnt_q - PH_W'(1);
                end
            end

            S_STROBE: begin
                if (ph_cnt_q == PH_W'(1)) begin
                    state_d  = S_HOLD;
                    ph_cnt_d = PH_W'(HOLD_CYC);
                    bus_d    = BUS_INACT;
                    // read data is sampled on the edge that ends the strobe
                    if (cmd_q == CMD_RD) begin
                        rdata_d  = ayd_i;
                        rvalid_d = 1'b1;
                    end
                end else begin
                    ph_cnt_d = ph_cnt_q - PH_W'(1);
                end
            end

            S_HOLD: begin
                if (ph_cnt_q == PH_W'(1)) begin
                    state_d  = S_RECOV;
                    rc_cnt_d = recov_load(cmd_q);
                    ayd_o_d  = 8'h00;
                    ayd_oe_d = 1'b0;
                    aya8_d   = 1'b0;
                    aya9_n_d = 1'b1;
                end else begin
                    ph_cnt_d = ph_cnt_q - PH_W'(1);
                end
            end

            S_RECOV: begin
                if (rc_cnt_q == RC_W'(1)) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else begin
                    rc_cnt_d = rc_cnt_q - RC_W'(1);
                end
            end

            default: begin
                state_d  = S_IDLE;
                ready_d  = 1'b1;
                ayd_o_d  = 8'h00;
                ayd_oe_d = 1'b0;
                bus_d    = BUS_INACT;
                aya8_d   = 1'b0;
                aya9_n_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset forces the bus inactive immediately.
    always_ff @(posedge fclk or negedge res_n) begin
        if (!res_n) begin
            state_q  <= S_IDLE;
            ph_cnt_q <= '0;
            rc_cnt_q <= '0;
            cmd_q    <= CMD_ADDR;
            ready    <= 1'b1;
            rdata    <= 8'h00;
            rvalid   <= 1'b0;
            ayd_o    <= 8'h00;
            ayd_oe   <= 1'b0;
            aybdir   <= BUS_INACT[2];
            aybc2    <= BUS_INACT[1];
            aybc1    <= BUS_INACT[0];
            aya8     <= 1'b0;
            aya9_n   <= 1'b1;
        end else begin
            state_q  <= state_d;
            ph_cnt_q <= ph_cnt_d;
            rc_cnt_q <= rc_cnt_d;
            cmd_q    <= cmd_d;
            ready    <= ready_d;
            rdata    <= rdata_d;
            rvalid   <= rvalid_d;
            ayd_o    <= ayd_o_d;
            ayd_oe   <= ayd_oe_d;
            aybdir   <= bus_d[2];
            aybc2    <= bus_d[1];
            aybc1    <= bus_d[0];
            aya8     <= aya8_d;
            aya9_n   <= aya9_n_d;
        end
    end

    // Parameters must fit the 4-bit phase and 10-bit recovery counters.
    always @(posedge fclk) begin
        assert (SETUP_CYC  >= 32'd1 && SETUP_CYC  <= PH_MAX) else $error("SETUP_CYC out of range");
        assert (STROBE_CYC >= 32'd1 && STROBE_CYC <= PH_MAX) else $error("STROBE_CYC out of range");
        assert (HOLD_CYC   >= 32'd1 && HOLD_CYC   <= PH_MAX) else $error("HOLD_CYC out of range");
        assert (ADDR_WAIT  >= 32'd1 && ADDR_WAIT  <= RC_MAX) else $error("ADDR_WAIT out of range");
        assert (DATA_WAIT  >= 32'd1 && DATA_WAIT  <= RC_MAX) else $error("DATA_WAIT out of range");
        assert (GAP_CYC    >= 32'd1 && GAP_CYC    <= RC_MAX) else $error("GAP_CYC out of range");
    end

endmodule

// File: tb/tb_ay_bus_master.sv
// Directed, table-driven bench for ay_bus_master: phase timing, bus codes,
// read capture, recovery lengths, ignored busy requests and async reset.
module tb_ay_bus_master;

    localparam int unsigned SETUP_N  = 2;
    localparam int unsigned STROBE_N = 4;
    localparam int unsigned HOLD_N   = 2;

    logic       fclk;
    logic       res_n;
    logic       req;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       ready;
    logic [7:0] rdata;
    logic       rvalid;
    logic [7:0] ayd_o;
    logic       ayd_oe;
    logic [7:0] ayd_i;
    logic       aybdir, aybc2, aybc1;
    logic       aya8, aya9_n;

    int checks = 0;
    int errors = 0;

    ay_bus_master dut (
        .fclk   (fclk),
        .res_n  (res_n),
        .req    (req),
        .cmd    (cmd),
        .wdata  (wdata),
        .ready  (ready),
        .rdata  (rdata),
        .rvalid (rvalid),
        .ayd_o  (ayd_o),
        .ayd_oe (ayd_oe),
        .ayd_i  (ayd_i),
        .aybdir (aybdir),
        .aybc2  (aybc2),
        .aybc1  (aybc1),
        .aya8   (aya8),
        .aya9_n (aya9_n)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    wire [2:0] bus = {aybdir, aybc2, aybc1};

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] wdata;
        logic [7:0] rd_in;
        logic [2:0] code;
        logic [7:0] exp_do;
        logic       exp_oe;
        int         exp_recov;
        logic [7:0] exp_rdata;
        logic       exp_rv;
        logic       busy_req;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Runs one transaction starting at a negedge with the DUT idle.
    task automatic run_vec(input vec_t v);
        int n;
        chk("start_ready", 16'(ready), 16'h1);
        cmd   = v.cmd;
        wdata = v.wdata;
        req   = 1'b1;
        @(negedge fclk);
        req = v.busy_req;
        if (v.busy_req) cmd = 2'b00;
        for (int i = 0; i < int'(SETUP_N); i++) begin
            chk("setup", {3'b0, ready, aya8, aya9_n, ayd_oe, bus, ayd_o},
                {3'b0, 1'b0, 1'b1, 1'b0, v.exp_oe, 3'b010, v.exp_do});
            @(negedge fclk);
        end
        for (int i = 0; i < int'(STROBE_N); i++) begin
            chk("strobe", {3'b0, ready, aya8, aya9_n, ayd_oe, bus, ayd_o},
                {3'b0, 1'b0, 1'b1, 1'b0, v.exp_oe, v.code, v.exp_do});
            chk("strobe_rvalid", 16'(rvalid), 16'h0);
            ayd_i = (i == int'(STROBE_N) - 1) ? v.rd_in : ~v.rd_in;
            @(negedge fclk);
        end
        req = 1'b0;
        for (int i = 0; i < int'(HOLD_N); i++) begin
            chk("hold", {3'b0, ready, aya8, aya9_n, ayd_oe, bus, ayd_o},
                {3'b0, 1'b0, 1'b1, 1'b0, v.exp_oe, 3'b010, v.exp_do});
            chk("hold_rvalid", 16'(rvalid), 16'((i == 0) && v.exp_rv));
            chk("hold_rdata", 16'(rdata), 16'(v.exp_rdata));
            @(negedge fclk);
        end
        n = 0;
        while (!ready && n < 2000) begin
            chk("recov", {4'b0, aya8, aya9_n, ayd_oe, rvalid, bus, ayd_o},
                {4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 8'h00});
            req = v.busy_req && (n >= 100) && (n < 110);
            @(negedge fclk);
            n++;
        end
        req = 1'b0;
        chk("recov_len", 16'(n), 16'(v.exp_recov));
        chk("end_rdata", 16'(rdata), 16'(v.exp_rdata));
        for (int i = 0; i < 3; i++) begin
            chk("post_idle", {4'b0, ready, aya8, aya9_n, ayd_oe, rvalid, bus, 4'b0},
                {4'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 4'b0});
            @(negedge fclk);
        end
    endtask

    initial begin
        //          cmd    wdata  rd_in  code    do     oe    recov rdata  rv    busy
        vecs[0] = '{2'b00, 8'h27, 8'h00, 3'b111, 8'h27, 1'b1, 136, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{2'b10, 8'h0E, 8'h5A, 3'b011, 8'h0E, 1'b0, 2,   8'h5A, 1'b1, 1'b0};
        vecs[2] = '{2'b11, 8'h0B, 8'h00, 3'b111, 8'hFB, 1'b1, 2,   8'h5A, 1'b0, 1'b0};
        vecs[3] = '{2'b01, 8'hC3, 8'h00, 3'b110, 8'hC3, 1'b1, 664, 8'h5A, 1'b0, 1'b1};
        vecs[4] = '{2'b10, 8'h07, 8'hA5, 3'b011, 8'h07, 1'b0, 2,   8'hA5, 1'b1, 1'b0};
        vecs[5] = '{2'b11, 8'hF4, 8'h00, 3'b111, 8'hF4, 1'b1, 2,   8'hA5, 1'b0, 1'b0};

        res_n = 1'b0;
        req   = 1'b0;
        cmd   = 2'b00;
        wdata = 8'h00;
        ayd_i = 8'h00;
        repeat (3) @(negedge fclk);
        res_n = 1'b1;

        // reset state held over idle cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge fclk);
            chk("idle", {ready, rvalid, aya8, aya9_n, ayd_oe, bus, rdata},
                {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 8'h00});
            chk("idle_do", 16'(ayd_o), 16'h0);
        end

        for (int k = 0; k < 6; k++) run_vec(vecs[k]);

        // reset in the middle of a data-write strobe
        cmd = 2'b01; wdata = 8'h99; req = 1'b1;
        @(negedge fclk);
        req = 1'b0;
        repeat (SETUP_N) @(negedge fclk);
        chk("rst_pre_strobe", {13'b0, bus}, {13'b0, 3'b110});
        @(negedge fclk);
        #1 res_n = 1'b0;
        #1;
        chk("rst_async", {3'b0, ready, aya8, aya9_n, ayd_oe, bus, rdata},
            {3'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 8'h00});
        @(negedge fclk);
        res_n = 1'b1;
        @(negedge fclk);
        chk("rst_release", {12'b0, ready, aya8, ayd_oe, rvalid}, {12'b0, 4'b1000});
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at %0t: got running expected finished", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ay_bus_master.md
Name: ay_bus_master

Overview:
- Host-side initiator for the AY-compatible sound-card bus on fclk.
- Converts single-word requests into correctly phased BDIR/BC2/BC1 bus cycles with address-line select, data drive and read-back capture.
- Request types: address latch, data write, data read, config write.
- Enforces YM2203 post-write recovery time before the next request is accepted.
- Serves as the board test driver and as the front end of an FPGA host replacing the Z80 port decoder.

Parameters:
- SETUP_CYC, 2, fclk cycles bus is held inactive with select/data valid before the strobe (1..15).
- STROBE_CYC, 4, fclk cycles the active BDIR/BC1 code is held (1..15).
- HOLD_CYC, 2, fclk cycles bus is held inactive with data still driven after the strobe (1..15).
- ADDR_WAIT, 136, recovery fclk cycles after an address latch (17 YM clocks x 8).
- DATA_WAIT, 664, recovery fclk cycles after a data write (83 YM clocks x 8).
- GAP_CYC, 2, recovery fclk cycles after a read or config write (>=1).

Ports:
- fclk  in  1  system clock, 28 MHz
- res_n  in  1  asynchronous active-low reset
- req  in  1  request strobe; accepted when req & ready
- cmd  in  2  00 address latch, 01 data write, 10 data read, 11 config write
- wdata  in  8  register number / write data; config write uses wdata[3:0]
- ready  out  1  high only in IDLE
- rdata  out  8  captured read data; holds until the next read
- rvalid  out  1  one-cycle pulse when rdata updates
- ayd_o  out  8  bus data out
- ayd_oe  out  1  bus data output enable
- ayd_i  in  8  bus data in
- aybdir, aybc2, aybc1  out  1 each  bus control
- aya8, aya9_n  out  1 each  chip select lines

Behaviour:
- Bus codes as (BDIR,BC2,BC1):
  - inactive = 010
  - address latch = 111
  - data write = 110
  - read = 011
  - config write = 111 with ayd_o[7:4]=1111 and ayd_o[3:0]=wdata[3:0]
- Async reset, and the idle state:
  - ready=1, rvalid=0, rdata=0, ayd_oe=0, ayd_o=0
  - bus inactive (010)
  - aya8=0, aya9_n=1
- States: IDLE, SETUP, STROBE, HOLD, RECOV.
  - Any state -> IDLE on reset, including mid-cycle: bus returns inactive and ayd_oe drops asynchronously.
- IDLE: on req & ready, register cmd and wdata, then go to SETUP next edge. req while not ready is ignored, with no queueing.
- SETUP, SETUP_CYC cycles:
  - aya8=1, aya9_n=0, bus inactive.
  - ayd_oe=1 for cmd 00/01/11; 0 for a read.
  - ayd_o = latched data.
- STROBE, STROBE_CYC cycles:
  - Active code driven; select and data unchanged.
  - For a read, ayd_oe=0 and rdata <= ayd_i is captured on the last STROBE edge.
- HOLD, HOLD_CYC cycles:
  - Bus inactive, select and data unchanged.
  - rvalid=1 in the first HOLD cycle of a read only.
- RECOV:
  - On entry: aya8=0, aya9_n=1, ayd_oe=0.
  - Counter loads ADDR_WAIT (cmd 00), DATA_WAIT (cmd 01) or GAP_CYC (10/11).
  - Counts down; IDLE when it reaches 1.
- Glitch-free outputs: aybdir/aybc1/aybc2/ayd_oe/aya8/aya9_n are all registered and change only on fclk rising edges. No combinational paths from inputs to outputs.
- Phase counter is 4 bits; recovery counter is 10 bits. Parameters exceeding those ranges are illegal; simulation flags them with an assertion.
- Transaction length is 1 (accept) + SETUP + STROBE + HOLD + recovery cycles. Defaults: write 1+2+4+2+664 = 673 fclk from accept to ready.
- Config write never uses DATA_WAIT. The decoder treats it as a deselect-and-latch, not a YM access.

Test Plan:
1. Reset, then idle 10 cycles -> ready=1, bus 010, aya8=0, aya9_n=1, ayd_oe=0, rdata=0.
2. cmd=00, wdata=0x27:
   - bus 010 for 2 cycles with ayd_o=0x27, ayd_oe=1, aya8=1, then 111 for 4 cycles, then 010 for 2 cycles.
   - ready returns exactly 136 cycles after HOLD ends.
3. cmd=10 with ayd_i=0x5A during STROBE:
   - ayd_oe stays 0, bus 011 for 4 cycles.
   - rdata=0x5A with a rvalid pulse in HOLD cycle 1; ready after GAP_CYC=2.
4. cmd=11, wdata=0x0B -> ayd_o=0xFB, bus 111 for 4 cycles; ready 2 cycles after HOLD.
5. cmd=01 sequence: check each bus code, 664-cycle recovery, and that req pulses during busy are ignored with no extra bus cycle.
6. Assert res_n low during STROBE of a data write -> bus 010 and ayd_oe=0 immediately (asynchronously); after release, ready=1 and the next request runs normally.
